ruby_l1d_req_arb: RTL and testbench

//  Shares one L1D request port among NUM_REQ LSU-side requesters (load pipe, store buffer, PTW).
//  - Round-robin arbitration with a per-requester outstanding-request limit.
//  - Prefixes the requester index onto the outgoing tag; demuxes returning responses by that prefix.
//  - Supports drain for fence/sfence. Sits between the LSU request queues and the ruby L1D input.

---
 rtl/ruby_l1d_req_arb.sv | 198 +++++++++++++++++++
 tb/tb_ruby_l1d_req_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ruby_l1d_req_arb.sv
// ruby_l1d_req_arb
//   Shares one ruby L1D request port among NUM_REQ LSU-side requesters
//   (load pipe, store buffer, PTW). Round-robin arbitration with a
//   per-requester outstanding-request limit. The requester index is
//   prefixed onto the outgoing tag, and returning responses are demuxed
//   by that prefix. drain_i blocks new grants for fence/sfence.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i/ready_o  per-requester handshake (ready_o is the grant)
//   req_tag_i            per-requester local tag, packed NUM_REQ*TAG_W
//   req_payload_i        per-requester payload, packed NUM_REQ*PAYLOAD_W
//   req_lock_i           per-requester grant hold (lock build only)
//   l1d_req_*            registered request to the L1D, tag = {idx, tag}
//   l1d_rsp_*            L1D response, no backpressure
//   rsp_valid_o          demuxed response valid, one bit per requester
//   rsp_tag_o/payload_o  shared response tag/payload bus
//   drain_i              block new grants
//   drain_done_o         drain_i & all counters zero & output reg empty
//   err_o                sticky: response to a bad index or to an idle counter
//
// Configuration
//   RUBY_L1D_ARB_LOCK_EN  when defined, granting i with req_lock_i[i]=1 makes
//                         only i eligible until a grant to i with
//                         req_lock_i[i]=0. Otherwise req_lock_i is ignored.
module ruby_l1d_req_arb #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned PAYLOAD_W = 160,
  parameter int unsigned RSP_W     = 72,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*TAG_W-1:0]       req_tag_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload_i,
  input  logic [NUM_REQ-1:0]             req_lock_i,
  output logic                           l1d_req_valid_o,
  input  logic                           l1d_req_ready_i,
  output logic [IDX_W+TAG_W-1:0]         l1d_req_tag_o,
  output logic [PAYLOAD_W-1:0]           l1d_req_payload_o,
  input  logic                           l1d_rsp_valid_i,
  input  logic [IDX_W+TAG_W-1:0]         l1d_rsp_tag_i,
  input  logic [RSP_W-1:0]               l1d_rsp_payload_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [TAG_W-1:0]               rsp_tag_o,
  output logic [RSP_W-1:0]               rsp_payload_o,
  input  logic                           drain_i,
  output logic                           drain_done_o,
  output logic                           err_o
);

  logic [IDX_W-1:0]           r_rr;
  logic [CNT_W-1:0]           r_cnt [NUM_REQ];
  logic                       r_out_valid;
  logic [IDX_W+TAG_W-1:0]     r_out_tag;
  logic [PAYLOAD_W-1:0]       r_out_payload;
  logic                       r_err;

  logic [NUM_REQ-1:0]         w_lock_ok;
  logic [NUM_REQ-1:0]         w_elig;
  logic                       w_load;
  logic                       w_found;
  logic                       w_grant;
  logic [IDX_W-1:0]           w_winner;
  int unsigned                w_rr_u;
  int unsigned                w_cand;
  logic [TAG_W-1:0]           w_sel_tag;
  logic [PAYLOAD_W-1:0]       w_sel_payload;
  logic [IDX_W-1:0]           w_rsp_idx;
  logic                       w_rsp_idx_ok;
  logic                       w_rsp_cnt_zero;
  logic                       w_all_zero;

`ifdef RUBY_L1D_ARB_LOCK_EN
  logic                       r_lock_act;
  logic [IDX_W-1:0]           r_lock_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      w_lock_ok[i] = ~r_lock_act | (r_lock_idx == IDX_W'(i));
  end
`else
  logic                       w_unused_lock;
  assign w_unused_lock = ^req_lock_i;
  assign w_lock_ok     = '1;
`endif

  // The output register may take a new request when empty or draining this cycle.
  assign w_load = ~r_out_valid | l1d_req_ready_i;
  assign w_rr_u = 32'(r_rr);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++)
      w_elig[i] = req_valid_i[i] & (r_cnt[i] < CNT_W'(MAX_OUTST)) & ~drain_i & w_lock_ok[i];
  end

  // First eligible requester at or after the round-robin pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_rr_u + k) % NUM_REQ;
      if (!w_found && w_elig[IDX_W'(w_cand)]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'(w_cand);
      end
    end
  end

  assign w_grant = w_load & w_found;

  always_comb begin
    req_ready_o   = '0;
    w_sel_tag     = '0;
    w_sel_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = w_grant & (w_winner == IDX_W'(i));
      if (w_winner == IDX_W'(i)) begin
        w_sel_tag     = req_tag_i[i*TAG_W +: TAG_W];
        w_sel_payload = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign w_rsp_idx    = l1d_rsp_tag_i[TAG_W +: IDX_W];
  assign w_rsp_idx_ok = 32'(w_rsp_idx) < NUM_REQ;

  always_comb begin
    rsp_valid_o    = '0;
    w_rsp_cnt_zero = 1'b0;
    w_all_zero     = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = l1d_rsp_valid_i & w_rsp_idx_ok & (w_rsp_idx == IDX_W'(i));
      if ((w_rsp_idx == IDX_W'(i)) && (r_cnt[i] == '0))
        w_rsp_cnt_zero = 1'b1;
      if (r_cnt[i] != '0)
        w_all_zero = 1'b0;
    end
  end

  assign rsp_tag_o         = l1d_rsp_tag_i[TAG_W-1:0];
  assign rsp_payload_o     = l1d_rsp_payload_i;
  assign l1d_req_valid_o   = r_out_valid;
  assign l1d_req_tag_o     = r_out_tag;
  assign l1d_req_payload_o = r_out_payload;
  assign err_o             = r_err;
  // Uses the registered counters: done follows the edge that retires the last response.
  assign drain_done_o      = drain_i & w_all_zero & ~r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr          <= '0;
      r_out_valid   <= 1'b0;
      r_out_tag     <= '0;
      r_out_payload <= '0;
      r_err         <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        r_cnt[i] <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_tag     <= {w_winner, w_sel_tag};
          r_out_payload <= w_sel_payload;
          r_rr          <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
      end
      // Grant and response in the same cycle cancel; a response to an idle counter leaves it at 0.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i] && !rsp_valid_o[i] && (r_cnt[i] < CNT_W'(MAX_OUTST)))
          r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (rsp_valid_o[i] && !req_ready_o[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      if (l1d_rsp_valid_i && (!w_rsp_idx_ok || w_rsp_cnt_zero))
        r_err <= 1'b1;
    end
  end

`ifdef RUBY_L1D_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_act <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_grant) begin
      r_lock_act <= req_lock_i[w_winner];
      r_lock_idx <= w_winner;
    end
  end
`endif

endmodule

// File: tb/tb_ruby_l1d_req_arb.sv
module tb_ruby_l1d_req_arb;
  localparam int N  = 3;
  localparam int TW = 4;
  localparam int PW = 160;
  localparam int RW = 72;
  localparam int MO = 4;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [TW-1:0]      tg [N];
  logic [PW-1:0]      pay [N];
  logic [N-1:0]       req_lock_i;
  logic               l1d_req_valid_o;
  logic               l1d_req_ready_i;
  logic [IW+TW-1:0]   l1d_req_tag_o;
  logic [PW-1:0]      l1d_req_payload_o;
  logic               l1d_rsp_valid_i;
  logic [IW+TW-1:0]   l1d_rsp_tag_i;
  logic [RW-1:0]      l1d_rsp_payload_i;
  logic [N-1:0]       rsp_valid_o;
  logic [TW-1:0]      rsp_tag_o;
  logic [RW-1:0]      rsp_payload_o;
  logic               drain_i;
  logic               drain_done_o;
  logic               err_o;

  always #5 clk = ~clk;

  ruby_l1d_req_arb #(
    .NUM_REQ(N), .TAG_W(TW), .PAYLOAD_W(PW), .RSP_W(RW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tag_i({tg[2], tg[1], tg[0]}),
    .req_payload_i({pay[2], pay[1], pay[0]}),
    .req_lock_i(req_lock_i),
    .l1d_req_valid_o(l1d_req_valid_o), .l1d_req_ready_i(l1d_req_ready_i),
    .l1d_req_tag_o(l1d_req_tag_o), .l1d_req_payload_o(l1d_req_payload_o),
    .l1d_rsp_valid_i(l1d_rsp_valid_i), .l1d_rsp_tag_i(l1d_rsp_tag_i),
    .l1d_rsp_payload_i(l1d_rsp_payload_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tag_o(rsp_tag_o), .rsp_payload_o(rsp_payload_o),
    .drain_i(drain_i), .drain_done_o(drain_done_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-requester outstanding counts, rr pointer, one-entry output slot.
  int           m_cnt [N];
  int           m_rr;
  bit           m_ov;
  logic [5:0]   m_otag;
  logic [PW-1:0] m_opay;
  bit           m_err;
  bit           m_lk;
  int           m_lki;
  logic [5:0]   acc_q [$];
  logic [N-1:0] obs_ready;

  task automatic chk(string nm, logic [159:0] obs, logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr = 0; m_ov = 0; m_otag = '0; m_opay = '0; m_err = 0; m_lk = 0; m_lki = 0;
    acc_q.delete();
  endtask

  function automatic bit lock_ok(int i);
`ifdef RUBY_L1D_ARB_LOCK_EN
    return !m_lk || (m_lki == i);
`else
    return (i >= 0);
`endif
  endfunction

  task automatic rsp_none();
    l1d_rsp_valid_i = 1'b0;
    l1d_rsp_tag_i = '0;
  endtask

  // Return the oldest accepted request belonging to 'want' (any requester if want<0).
  task automatic rsp_pop(int want);
    rsp_none();
    for (int k = 0; k < acc_q.size(); k++) begin
      if (want < 0 || int'(acc_q[k][5:4]) == want) begin
        l1d_rsp_valid_i = 1'b1;
        l1d_rsp_tag_i = acc_q[k];
        l1d_rsp_payload_i = RW'({$urandom, $urandom, $urandom});
        acc_q.delete(k);
        break;
      end
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    int win, idx;
    bit load, dd;
    logic [N-1:0] er, ev;
    #2;
    load = !m_ov || l1d_req_ready_i;
    win = -1;
    if (load)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (win < 0 && req_valid_i[i] && m_cnt[i] < MO && !drain_i && lock_ok(i)) win = i;
      end
    idx = int'(l1d_rsp_tag_i[5:4]);
    dd = drain_i && !m_ov;
    for (int i = 0; i < N; i++) begin
      er[i] = (win == i);
      ev[i] = l1d_rsp_valid_i && (idx == i);
      if (m_cnt[i] != 0) dd = 0;
    end
    chk("req_ready", 160'(req_ready_o), 160'(er));
    chk("rsp_valid", 160'(rsp_valid_o), 160'(ev));
    chk("drain_done", 160'(drain_done_o), 160'(dd));
    if (l1d_rsp_valid_i) begin
      chk("rsp_tag", 160'(rsp_tag_o), 160'(l1d_rsp_tag_i[3:0]));
      chk("rsp_payload", 160'(rsp_payload_o), 160'(l1d_rsp_payload_i));
    end
    obs_ready = req_ready_o;
    @(posedge clk); #1;
    if (m_ov && l1d_req_ready_i) acc_q.push_back(m_otag);
    if (load) begin
      m_ov = (win >= 0);
      if (win >= 0) begin
        m_otag = {2'(win), tg[win]};
        m_opay = pay[win];
        m_rr = (win + 1) % N;
        m_lk = req_lock_i[win];
        m_lki = win;
      end
    end
    if (l1d_rsp_valid_i && (idx >= N || m_cnt[idx] == 0)) m_err = 1;
    for (int i = 0; i < N; i++) begin
      if (win == i && !(l1d_rsp_valid_i && idx == i)) m_cnt[i]++;
      else if (l1d_rsp_valid_i && idx == i && win != i && m_cnt[i] > 0) m_cnt[i]--;
    end
    chk("l1d_valid", 160'(l1d_req_valid_o), 160'(m_ov));
    if (m_ov) begin
      chk("l1d_tag", 160'(l1d_req_tag_o), 160'(m_otag));
      chk("l1d_payload", 160'(l1d_req_payload_o), 160'(m_opay));
    end
    chk("err", 160'(err_o), 160'(m_err));
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      tg[i] = TW'($urandom);
      pay[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic flush();
    for (int n = 0; n < 40; n++) begin
      if (acc_q.size() == 0 && !m_ov) break;
      req_valid_i = '0; l1d_req_ready_i = 1'b1; drain_i = 1'b0;
      rsp_pop(-1);
      cycle();
    end
    rsp_none();
  endtask

  initial begin
    logic [2:0] rr_exp [6];
    logic [5:0] hold_tag;
    logic [PW-1:0] hold_pay;
    int gcount;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    rst_n = 1'b0; req_valid_i = '0; req_lock_i = '0; l1d_req_ready_i = 1'b0;
    drain_i = 1'b0; l1d_rsp_payload_i = '0;
    rsp_none(); randomize_reqs(); m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_l1d_valid", 160'(l1d_req_valid_o), 160'(0));
    chk("rst_ready", 160'(req_ready_o), 160'(0));
    chk("rst_err", 160'(err_o), 160'(0));
    chk("rst_rsp_valid", 160'(rsp_valid_o), 160'(0));
    rst_n = 1'b1;

    // Round-robin fairness
    req_valid_i = 3'b111; l1d_req_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      randomize_reqs();
      cycle();
      chk("rr_seq", 160'(obs_ready), 160'(rr_exp[k]));
    end
    flush();

    // Outstanding limit on requester 0
    gcount = 0;
    req_valid_i = 3'b001;
    for (int k = 0; k < 6; k++) begin
      randomize_reqs();
      cycle();
      gcount += int'(obs_ready[0]);
    end
    chk("limit_grants", 160'(gcount), 160'(4));
    chk("limit_blocked", 160'(obs_ready), 160'(0));
    rsp_pop(0);
    cycle();
    rsp_none();
    cycle();
    chk("limit_regrant", 160'(obs_ready), 160'(3'b001));
    flush();

    // Backpressure
    req_valid_i = 3'b111; l1d_req_ready_i = 1'b0;
    randomize_reqs();
    cycle();
    hold_tag = l1d_req_tag_o; hold_pay = l1d_req_payload_o;
    for (int k = 0; k < 4; k++) begin
      randomize_reqs();
      cycle();
      chk("bp_tag_stable", 160'(l1d_req_tag_o), 160'(hold_tag));
      chk("bp_pay_stable", 160'(l1d_req_payload_o), 160'(hold_pay));
      chk("bp_no_grant", 160'(obs_ready), 160'(0));
    end
    flush();

    // Simultaneous grant and response on requester 1, then a bad index
    req_valid_i = 3'b010; l1d_req_ready_i = 1'b1;
    cycle();
    req_valid_i = '0;
    cycle();
    req_valid_i = 3'b010; randomize_reqs(); rsp_pop(1);
    cycle();
    chk("simul_grant", 160'(obs_ready), 160'(3'b010));
    req_valid_i = '0; rsp_none(); drain_i = 1'b1;
    cycle(); cycle();
    chk("simul_cnt_kept", 160'(drain_done_o), 160'(0));
    rsp_pop(1);
    cycle();
    rsp_none();
    cycle();
    drain_i = 1'b0;
    l1d_rsp_valid_i = 1'b1; l1d_rsp_tag_i = 6'b11_0101;
    cycle();
    chk("bad_idx_err", 160'(err_o), 160'(1));
    rsp_none();

    // Reset in the middle of a held transfer
    req_valid_i = 3'b001; l1d_req_ready_i = 1'b0;
    cycle();
    req_valid_i = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_reset();
    chk("mid_rst_valid", 160'(l1d_req_valid_o), 160'(0));
    chk("mid_rst_ready", 160'(req_ready_o), 160'(0));
    chk("mid_rst_err", 160'(err_o), 160'(0));
    drain_i = 1'b1; #1;
    chk("mid_rst_cnt_zero", 160'(drain_done_o), 160'(1));
    drain_i = 1'b0; rst_n = 1'b1;

    // Drain with counts {1,0,2}
    l1d_req_ready_i = 1'b1;
    req_valid_i = 3'b001; cycle();
    req_valid_i = 3'b100; cycle(); cycle();
    req_valid_i = '0; cycle(); cycle();
    drain_i = 1'b1; req_valid_i = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("drain_no_grant", 160'(obs_ready), 160'(0));
    end
    for (int k = 0; k < 3; k++) begin
      rsp_pop(-1);
      cycle();
    end
    rsp_none(); #1;
    chk("drain_done_last", 160'(drain_done_o), 160'(1));
    cycle();
    drain_i = 1'b0;
    cycle();
    flush();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid_i = N'($urandom_range(0, 7));
      req_lock_i = N'($urandom_range(0, 7));
      l1d_req_ready_i = ($urandom_range(0, 3) != 0);
      drain_i = ($urandom_range(0, 15) == 0);
      randomize_reqs();
      rsp_none();
      if (acc_q.size() > 0 && $urandom_range(0, 9) < 4) begin
        int k;
        k = int'($urandom_range(0, acc_q.size() - 1));
        l1d_rsp_valid_i = 1'b1;
        l1d_rsp_tag_i = acc_q[k];
        l1d_rsp_payload_i = RW'({$urandom, $urandom, $urandom});
        acc_q.delete(k);
      end else if (c > 370 && $urandom_range(0, 9) == 0) begin
        l1d_rsp_valid_i = 1'b1;
        l1d_rsp_tag_i = {2'b11, 4'($urandom)};
      end
      cycle();
    end
    req_lock_i = '0;
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
